// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the MIPS-subset datapath.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// every datapath control input. Architectural writes (GPR, DM, PC) happen
// only in the last state of each instruction.
//
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to add the instr_cnt and
// cycle_cnt performance counter outputs.
//
// state  | meaning
// FETCH  | load IR (ir_write), all selects 0
// DECODE | classify opcode/funct into cls, selects follow the new class
// EXEC   | ALU evaluates, overflow captured into ovf_q
// MEM    | data memory access (lw read, sw write)
// WB     | GPR write-back
module multicycle_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       positive,
    output logic [1:0] alu_ctl,
    output logic       ext_op,
    output logic [2:0] reg_src,
    output logic       npc_sel,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] reg_dst,
    output logic       j_ctl,
    output logic       jr_ctl,
    output logic       pc_write,
    output logic       ir_write,
    output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_ADDI, C_LW,
        C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILL
    } cls_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    localparam logic [2:0] SRC_ALU  = 3'd0;
    localparam logic [2:0] SRC_MEM  = 3'd1;
    localparam logic [2:0] SRC_ONE  = 3'd3;
    localparam logic [2:0] SRC_PC   = 3'd4;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R30 = 2'd2;
    localparam logic [1:0] DST_R31 = 2'd3;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    cls_t   cls_dec, cls_cur;
    logic   ovf_q, ovf_d;
    logic   illegal_q, illegal_d;

    // The ALU "positive" flag is reserved for future branch types.
    logic unused_positive;
    assign unused_positive = positive;

    function automatic cls_t decode_cls(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        c = C_ILL;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: c = C_ADDU;
                    6'b100011: c = C_SUBU;
                    6'b001000: c = C_JR;
                    default:   c = C_ILL;
                endcase
            end
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b001000: c = C_ADDI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    // Selects must already reflect the new instruction during DECODE, before
    // cls_q has been loaded, so DECODE uses the live decode.
    always_comb begin
        cls_dec = decode_cls(opcode, funct);
        cls_cur = (state_q == S_DECODE) ? cls_dec : cls_q;
    end

    // Next-state, class latch, overflow capture and sticky illegal flag.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cls_d   = cls_dec;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ovf_d = overflow;
                case (cls_q)
                    C_LW, C_SW:                                   state_d = S_MEM;
                    C_ADDU, C_SUBU, C_ORI, C_LUI, C_ADDI, C_JAL:  state_d = S_WB;
                    default:                                      state_d = S_FETCH;
                endcase
                if (cls_q == C_ILL) begin
                    illegal_d = 1'b1;
                end
            end
            S_MEM:    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control outputs decoded from the registered state. ir_write is gated by
    // rst so that nothing is asserted while reset is held, yet the very first
    // FETCH after release already loads the IR.
    always_comb begin
        alu_ctl   = ALU_ADD;
        ext_op    = 1'b0;
        reg_src   = SRC_ALU;
        npc_sel   = 1'b0;
        alu_src   = 1'b0;
        reg_dst   = DST_RT;
        j_ctl     = 1'b0;
        jr_ctl    = 1'b0;
        ir_write  = (state_q == S_FETCH) && rst;
        reg_write = (state_q == S_WB);
        mem_write = (state_q == S_MEM) && (cls_q == C_SW);
        pc_write  = (state_q != S_FETCH) && (state_d == S_FETCH);
        illegal   = illegal_q;
        if (state_q != S_FETCH) begin
            case (cls_cur)
                C_ADDU: begin
                    alu_ctl = ALU_ADD;
                    reg_dst = DST_RD;
                    reg_src = SRC_ALU;
                end
                C_SUBU: begin
                    alu_ctl = ALU_SUB;
                    reg_dst = DST_RD;
                    reg_src = SRC_ALU;
                end
                C_ORI: begin
                    alu_ctl = ALU_OR;
                    alu_src = 1'b1;
                    reg_dst = DST_RT;
                end
                C_LUI: begin
                    alu_ctl = ALU_LUI;
                    alu_src = 1'b1;
                    reg_dst = DST_RT;
                end
                C_ADDI: begin
                    alu_ctl = ALU_ADD;
                    ext_op  = 1'b1;
                    alu_src = 1'b1;
                    // On overflow the result is discarded and $30 is set to 1.
                    if ((state_q == S_WB) && ovf_q) begin
                        reg_dst = DST_R30;
                        reg_src = SRC_ONE;
                    end else begin
                        reg_dst = DST_RT;
                        reg_src = SRC_ALU;
                    end
                end
                C_LW: begin
                    alu_ctl = ALU_ADD;
                    ext_op  = 1'b1;
                    alu_src = 1'b1;
                    reg_dst = DST_RT;
                    reg_src = SRC_MEM;
                end
                C_SW: begin
                    alu_ctl = ALU_ADD;
                    ext_op  = 1'b1;
                    alu_src = 1'b1;
                end
                C_BEQ: begin
                    alu_ctl = ALU_SUB;
                    npc_sel = 1'b1;
                end
                C_J:   j_ctl = 1'b1;
                C_JAL: begin
                    j_ctl   = 1'b1;
                    reg_dst = DST_R31;
                    reg_src = SRC_PC;
                end
                C_JR:  jr_ctl = 1'b1;
                default: ;
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= state_t'(RESET_STATE);
            cls_q     <= C_NOP;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    // Retired-instruction and active-cycle counters, both free-wrapping.
    always_comb begin
        instr_cnt_d = instr_cnt_q + {31'd0, pc_write};
        cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences
// followed by random instructions, each cycle compared against a
// cycle-index model of the instruction's expected control pattern.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       positive;
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic [2:0] reg_src;
    logic       npc_sel;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       j_ctl;
    logic       jr_ctl;
    logic       pc_write;
    logic       ir_write;
    logic       illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;
`endif

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .overflow  (overflow),
        .positive  (positive),
        .alu_ctl   (alu_ctl),
        .ext_op    (ext_op),
        .reg_src   (reg_src),
        .npc_sel   (npc_sel),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .reg_dst   (reg_dst),
        .j_ctl     (j_ctl),
        .jr_ctl    (jr_ctl),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .illegal   (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .instr_cnt (instr_cnt),
        .cycle_cnt (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {alu_ctl, ext_op, reg_src, npc_sel, mem_write, reg_write,
                  alu_src, reg_dst, j_ctl, jr_ctl, pc_write, ir_write, illegal};

    typedef enum int {
        B_ADDU, B_SUBU, B_ORI, B_LUI, B_ADDI, B_LW, B_SW,
        B_BEQ, B_J, B_JAL, B_JR, B_ILL
    } bcls_t;

    int n_vec = 0;
    int n_err = 0;
    logic sticky = 1'b0;
    int m_instr = 0;
    int m_cycle = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bcls_t classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (fn == 6'b100001) return B_ADDU;
            if (fn == 6'b100011) return B_SUBU;
            if (fn == 6'b001000) return B_JR;
            return B_ILL;
        end
        case (op)
            6'b001101: return B_ORI;
            6'b001111: return B_LUI;
            6'b001000: return B_ADDI;
            6'b100011: return B_LW;
            6'b101011: return B_SW;
            6'b000100: return B_BEQ;
            6'b000010: return B_J;
            6'b000011: return B_JAL;
            default:   return B_ILL;
        endcase
    endfunction

    function automatic int cycles_of(input bcls_t c);
        if (c == B_LW) return 5;
        if (c inside {B_ADDU, B_SUBU, B_ORI, B_LUI, B_ADDI, B_JAL, B_SW}) return 4;
        return 3;
    endfunction

    // Expected control word in cycle k (1-based) of an instruction of class c.
    function automatic logic [16:0] model_vec(input bcls_t c, input int k,
                                              input logic ovf, input logic stk);
        int         len;
        logic [1:0] alu;
        logic       ext;
        logic [2:0] rs;
        logic       npc;
        logic       as;
        logic [1:0] rd;
        logic       jc;
        logic       jrc;
        logic       rw;
        logic       mw;
        len = cycles_of(c);
        alu = 2'd0; ext = 1'b0; rs = 3'd0; npc = 1'b0; as = 1'b0;
        rd = 2'd0; jc = 1'b0; jrc = 1'b0;
        if (k >= 2) begin
            case (c)
                B_ADDU: begin alu = 2'd0; rd = 2'd1; end
                B_SUBU: begin alu = 2'd1; rd = 2'd1; end
                B_ORI:  begin alu = 2'd2; as = 1'b1; end
                B_LUI:  begin alu = 2'd3; as = 1'b1; end
                B_ADDI: begin alu = 2'd0; ext = 1'b1; as = 1'b1; end
                B_LW:   begin alu = 2'd0; ext = 1'b1; as = 1'b1; rs = 3'd1; end
                B_SW:   begin alu = 2'd0; ext = 1'b1; as = 1'b1; end
                B_BEQ:  begin alu = 2'd1; npc = 1'b1; end
                B_J:    jc = 1'b1;
                B_JAL:  begin jc = 1'b1; rd = 2'd3; rs = 3'd4; end
                B_JR:   jrc = 1'b1;
                default: ;
            endcase
        end
        if (c == B_ADDI && k == len && ovf) begin
            rd = 2'd2;
            rs = 3'd3;
        end
        rw = (k == len) && (c inside {B_ADDU, B_SUBU, B_ORI, B_LUI, B_ADDI, B_LW, B_JAL});
        mw = (k == len) && (c == B_SW);
        return {alu, ext, rs, npc, mw, rw, as, rd, jc, jrc, (k == len), (k == 1), stk};
    endfunction

    // Runs one instruction starting in its FETCH cycle. ovf_mode <0 drives a
    // random overflow in EXEC, otherwise the given value. abort_at >0 asserts
    // reset during that cycle and ends the instruction there.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int ovf_mode, input int abort_at);
        bcls_t c;
        int    len;
        logic  ovf_seen;
        string tag;
        c = classify(op, fn);
        len = cycles_of(c);
        ovf_seen = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            opcode   = (k == 2) ? op : 6'($urandom);
            funct    = (k == 2) ? fn : 6'($urandom);
            overflow = 1'($urandom);
            positive = 1'($urandom);
            if (k == 3) begin
                if (ovf_mode >= 0) overflow = 1'(ovf_mode);
                ovf_seen = overflow;
            end
            #1;
            tag = $sformatf("%s c%0d", c.name(), k);
            chk(tag, {15'd0, obs}, {15'd0, model_vec(c, k, ovf_seen, sticky)});
`ifdef MULTICYCLE_CTRL_PERF_EN
            if (k == 1) begin
                chk("instr_cnt", instr_cnt, m_instr);
                chk("cycle_cnt", cycle_cnt, m_cycle);
            end
`endif
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                chk("rst_abort", {15'd0, obs}, 32'd0);
                @(negedge clk);
                chk("rst_hold", {15'd0, obs}, 32'd0);
                @(posedge clk);
                #2;
                rst = 1'b1;
                sticky = 1'b0;
                m_instr = 0;
                m_cycle = 0;
                return;
            end
            m_cycle++;
        end
        m_instr++;
        if (c == B_ILL) sticky = 1'b1;
    endtask

    logic [5:0] legal_op [11] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101,
                                  6'b001111, 6'b001000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b000010, 6'b000011};
    logic [5:0] legal_fn [3]  = '{6'b100001, 6'b100011, 6'b001000};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         r;
        rst = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        overflow = 1'b0;
        positive = 1'b0;
        repeat (3) @(negedge clk);
        opcode = 6'b000000;
        funct  = 6'b100001;
        #1;
        chk("reset", {15'd0, obs}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        run_instr(6'b000000, 6'b100001, -1, 0);  // addu
        run_instr(6'b100011, 6'b010101, -1, 0);  // lw
        run_instr(6'b101011, 6'b000000, -1, 0);  // sw
        run_instr(6'b001000, 6'b000011, 1, 0);   // addi, overflow
        run_instr(6'b001000, 6'b000011, 0, 0);   // addi, no overflow
        run_instr(6'b000100, 6'b111111, -1, 0);  // beq
        run_instr(6'b000010, 6'b000000, -1, 0);  // j
        run_instr(6'b000000, 6'b001000, -1, 0);  // jr
        run_instr(6'b000011, 6'b000000, -1, 0);  // jal
        run_instr(6'b000000, 6'b100011, -1, 0);  // subu
        run_instr(6'b111111, 6'b000000, -1, 0);  // illegal opcode
        run_instr(6'b000000, 6'b100001, -1, 0);  // addu, illegal still set
        run_instr(6'b000000, 6'b000000, -1, 0);  // illegal funct
        run_instr(6'b100011, 6'b000000, -1, 4);  // lw aborted in MEM
        run_instr(6'b000000, 6'b100001, -1, 0);  // addu
        run_instr(6'b000000, 6'b100001, -1, 0);  // addu
        run_instr(6'b001101, 6'b000000, -1, 0);  // ori, counters 2/8 at fetch

        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 12);
            if (r < 11) begin
                op = legal_op[r];
                fn = (r < 3) ? legal_fn[r] : 6'($urandom);
            end else begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (classify(op, fn) != B_ILL);
            end
            run_instr(op, fn, -1, ($urandom_range(0, 29) == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main controller for the MIPS-subset datapath.
- Consumes the datapath's opcode/funct/overflow/positive outputs and drives every datapath control input.
- Adds pc_write/ir_write strobes so each instruction spans 3-5 cycles, and gates all architectural writes (GPR, DM, PC) to the final state of each instruction.

Parameters:
- RESET_STATE, 3'd0, encoding of FETCH; the state register loads this value on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from datapath.
- funct  in  6  instruction[5:0] from datapath.
- overflow  in  1  ALU signed overflow.
- positive  in  1  ALU result > 0; unused by the current ISA, reserved.
- alu_ctl  out  2  ALU op: 00 ADD, 01 SUB, 10 OR, 11 LUI (B<<16).
- ext_op  out  1  0 zero-extend, 1 sign-extend.
- reg_src  out  3  GPR write data: 0 ALU, 1 MEM, 2 ZERO, 3 ONE, 4 PC.
- npc_sel  out  1  1 = branch-if-zero path in the IFU.
- mem_write  out  1  DM write enable.
- reg_write  out  1  GPR write enable.
- alu_src  out  1  0 = rt register, 1 = extended immediate.
- reg_dst  out  2  write address: 0 rt, 1 rd, 2 $30, 3 $31.
- j_ctl  out  1  jump-immediate PC select.
- jr_ctl  out  1  jump-register PC select.
- pc_write  out  1  PC update strobe.
- ir_write  out  1  instruction register load strobe.
- illegal  out  1  sticky: an undecoded instruction was seen.

Behaviour:
- Reset (rst=0, async): state=FETCH, cls=NOP, ovf_q=0, illegal=0. All outputs 0 while in reset.
- Reset mid-instruction aborts it with no GPR/DM/PC write.
- States:
  - FETCH: ir_write=1.
  - DECODE: latch instruction class cls from opcode/funct.
  - EXEC: ALU evaluates; ovf_q<=overflow.
  - MEM: memory access.
  - WB: register write.
- Decode:
  - R-type (opcode 000000): addu funct 100001, subu 100011, jr 001000.
  - I-type opcodes: ori 001101, lui 001111, addi 001000, lw 100011, sw 101011, beq 000100.
  - J-type opcodes: j 000010, jal 000011.
  - Anything else is ILLEGAL.
- Sequences and latency:
  - addu/subu/ori/lui/addi/jal: FETCH-DECODE-EXEC-WB, 4 cycles.
  - lw: FETCH-DECODE-EXEC-MEM-WB, 5 cycles.
  - sw: FETCH-DECODE-EXEC-MEM, 4 cycles.
  - beq/j/jr/ILLEGAL: FETCH-DECODE-EXEC, 3 cycles.
- Strobes:
  - reg_write is 1 only in WB. mem_write is 1 only in MEM for sw.
  - pc_write is 1 exactly once per instruction, in its last state; the next state is then FETCH.
- Mux selects (alu_ctl, ext_op, alu_src, reg_src, reg_dst, npc_sel, j_ctl, jr_ctl) are driven from cls in DECODE..last state, stable throughout. All are 0 in FETCH.
- Per class:
  - addu/subu: alu_ctl ADD/SUB, alu_src 0, reg_dst rd, reg_src ALU; overflow ignored.
  - ori: OR, ext_op 0, alu_src 1, reg_dst rt.
  - lui: LUI, ext_op 0, alu_src 1, reg_dst rt.
  - addi: ADD, ext_op 1, alu_src 1. WB with ovf_q=0: reg_dst rt, reg_src ALU. WB with ovf_q=1: reg_dst $30, reg_src ONE (rt untouched).
  - lw: ADD, ext_op 1, alu_src 1, reg_dst rt, reg_src MEM.
  - sw: ADD, ext_op 1, alu_src 1.
  - beq: SUB, alu_src 0, npc_sel 1.
  - j: j_ctl 1.
  - jal: j_ctl 1, reg_dst $31, reg_src PC. pc_write is in WB, so $31 receives the pre-jump npc.
  - jr: jr_ctl 1.
  - ILLEGAL: all selects 0, pc_write in EXEC (PC+4), illegal<=1 and held until reset.
- opcode/funct are sampled only in DECODE; changes at other times are ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - Adds outputs instr_cnt[31:0] (+1 on every pc_write) and cycle_cnt[31:0] (+1 every cycle out of reset).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Release rst in FETCH; present addu (000000/100001) -> ir_write cycle 1, reg_dst=1, reg_src=0, reg_write=1 only cycle 4, pc_write=1 cycle 4, back in FETCH cycle 5.
- lw (100011) then sw (101011) -> lw: reg_src=1, reg_write cycle 5 only, mem_write never. sw: mem_write=1 cycle 4 only, reg_write never, pc_write cycle 4.
- addi with overflow=1 during EXEC -> WB: reg_dst=2, reg_src=3, reg_write=1. Repeat with overflow=0 -> reg_dst=0, reg_src=0.
- beq, j, jr, jal -> beq npc_sel=1, j j_ctl=1, jr jr_ctl=1: each pc_write cycle 3, no reg_write. jal: reg_dst=3, reg_src=4, reg_write and pc_write both cycle 4.
- opcode 111111 -> illegal=1 from cycle 4, stays 1 across a following addu, pc_write cycle 3, no reg/mem write.
- Assert rst=0 during lw MEM -> outputs 0 immediately, no reg_write. After release, FETCH and illegal=0. With MULTICYCLE_CTRL_PERF_EN, after 2 addu instructions instr_cnt=2, cycle_cnt=8.
